// File: rtl/divider_display_if.sv
// Result bus from the 4-bit divider into the display stage.
// The divider drives; the display only samples.
interface divider_display_if;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       error;

  modport master (
    output done, quotient, remainder, error
  );
  modport slave (
    input done, quotient, remainder, error
  );
endinterface

// File: rtl/divider_display.sv
// Captures divider results on done rising edges and scans them
// onto four common-anode 7-segment digits (q left, r right).
module divider_display #(
  parameter int SCAN_DIV = 100000
) (
  input  logic                clk,
  input  logic                rst,
  divider_display_if.slave    div,
  output logic [3:0]          an,
  output logic [6:0]          seg,
  output logic                result_valid,
  output logic                err_led
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    slot_q, slot_d;
  logic          done_q, done_d;
  logic [3:0]    quo_q, quo_d;
  logic [3:0]    rem_q, rem_d;
  logic          err_q, err_d;
  logic          have_q, have_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic [3:0]    val;
  logic          big;
  logic [3:0]    ones;

  function automatic logic [6:0] dec(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  always_comb begin
    pre_d  = pre_q;
    slot_d = slot_q;
    done_d = div.done;
    quo_d  = quo_q;
    rem_d  = rem_q;
    err_d  = err_q;
    have_d = have_q;

    if (pre_q == PRE_MAX) begin
      pre_d  = '0;
      slot_d = slot_q + 2'd1;
    end else begin
      pre_d  = pre_q + 1'b1;
    end

    if (div.done && !done_q) begin
      quo_d  = div.quotient;
      rem_d  = div.remainder;
      err_d  = div.error;
      have_d = 1'b1;
    end

    // Odd slots hold tens digits, slots 3/2 hold the quotient.
    val  = slot_q[1] ? quo_q : rem_q;
    big  = (val >= 4'd10);
    ones = big ? (val - 4'd10) : val;

    an_d = ~(4'b0001 << slot_q);

    if (!have_q) begin
      seg_d = SEG_DASH;
    end else if (err_q) begin
      if (slot_q == 2'd3)
        seg_d = SEG_E;
      else if (slot_q == 2'd0)
        seg_d = SEG_BLANK;
      else
        seg_d = SEG_R;
    end else if (slot_q[0]) begin
      seg_d = big ? dec(4'd1) : SEG_BLANK;
    end else begin
      seg_d = dec(ones);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      slot_q <= 2'd0;
      done_q <= 1'b0;
      quo_q  <= 4'd0;
      rem_q  <= 4'd0;
      err_q  <= 1'b0;
      have_q <= 1'b0;
      an_q   <= 4'b1111;
      seg_q  <= SEG_BLANK;
    end else begin
      pre_q  <= pre_d;
      slot_q <= slot_d;
      done_q <= done_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      err_q  <= err_d;
      have_q <= have_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign an           = an_q;
  assign seg          = seg_q;
  assign result_valid = have_q;
  assign err_led      = err_q;

endmodule

// File: tb/tb_divider_display.sv
// Directed bench for divider_display with a cycle-counting model
// and literal segment pins per scenario.
module tb_divider_display;

  localparam int SCAN = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] an;
  logic [6:0] seg;
  logic       result_valid;
  logic       err_led;

  divider_display_if bus ();

  divider_display #(.SCAN_DIV(SCAN)) dut (
    .clk          (clk),
    .rst          (rst),
    .div          (bus.slave),
    .an           (an),
    .seg          (seg),
    .result_valid (result_valid),
    .err_led      (err_led)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;
  logic [6:0] digits [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [6:0] mseg(input int slot, input bit have,
                                      input bit err, input int q,
                                      input int r);
    int v;
    if (!have) return DASH;
    if (err) begin
      if (slot == 3) return 7'b0000110;
      if (slot == 0) return BLANK;
      return 7'b0101111;
    end
    v = (slot >= 2) ? q : r;
    if (slot == 1 || slot == 3)
      return (v / 10 == 0) ? BLANK : digits[v / 10];
    return digits[v % 10];
  endfunction

  // Model: outputs follow from edges counted since reset and
  // the result held before the current edge.
  int         n_edges;
  bit         prev_done;
  int         m_q, m_r;
  bit         m_err, m_have;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin
    int s;
    if (rst) begin
      n_edges   = 0;
      prev_done = 1'b0;
      m_q = 0; m_r = 0; m_err = 1'b0; m_have = 1'b0;
      exp_an  = 4'b1111;
      exp_seg = BLANK;
      chk_en  = 1'b1;
    end else begin
      s       = (n_edges / SCAN) % 4;
      exp_an  = ~(4'b0001 << s);
      exp_seg = mseg(s, m_have, m_err, m_q, m_r);
      if (bus.done && !prev_done) begin
        m_q = int'(bus.quotient);
        m_r = int'(bus.remainder);
        m_err = bus.error;
        m_have = 1'b1;
      end
      prev_done = bus.done;
      n_edges++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("an", 32'(an), 32'(exp_an));
      chk("seg", 32'(seg), 32'(exp_seg));
      chk("result_valid", 32'(result_valid), 32'(m_have));
      chk("err_led", 32'(err_led), 32'(m_err));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pin(input logic [3:0] a, input logic [6:0] s,
                     input string nm);
    int k = 0;
    while (an !== a && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) chk({nm, "_timeout"}, 32'(an), 32'(a));
    else chk(nm, 32'(seg), 32'(s));
  endtask

  task automatic pulse(input logic [3:0] q, input logic [3:0] r,
                       input logic e);
    bus.quotient = q; bus.remainder = r; bus.error = e;
    bus.done = 1'b1;
    cyc(1);
    bus.done = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.done = 1'b0; bus.quotient = 4'd0;
    bus.remainder = 4'd0; bus.error = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    chk("rel_an", 32'(an), 32'(4'b1110));
    chk("rel_seg", 32'(seg), 32'(DASH));
    chk("rel_valid", 32'(result_valid), 32'd0);
    cyc(20);

    pulse(4'd13, 4'd7, 1'b0);
    chk("cap_valid", 32'(result_valid), 32'd1);
    cyc(17);
    pin(4'b1110, 7'b1111000, "q13_s0");
    pin(4'b1101, 7'b1111111, "q13_s1");
    pin(4'b1011, 7'b0110000, "q13_s2");
    pin(4'b0111, 7'b1111001, "q13_s3");

    bus.quotient = 4'd2; bus.remainder = 4'd0; bus.error = 1'b0;
    bus.done = 1'b1;
    cyc(10);
    bus.quotient = 4'd9;
    cyc(6);
    bus.done = 1'b0;
    cyc(1);
    pin(4'b1011, 7'b0100100, "held_s2");
    pulse(4'd9, 4'd0, 1'b0);
    cyc(17);
    pin(4'b1011, 7'b0010000, "new9_s2");

    pulse(4'd3, 4'd1, 1'b1);
    chk("err_led", 32'(err_led), 32'd1);
    cyc(17);
    pin(4'b1110, 7'b1111111, "err_s0");
    pin(4'b1101, 7'b0101111, "err_s1");
    pin(4'b1011, 7'b0101111, "err_s2");
    pin(4'b0111, 7'b0000110, "err_s3");

    pulse(4'd0, 4'd0, 1'b0);
    cyc(17);
    pin(4'b1110, 7'b1000000, "zero_s0");
    pin(4'b1101, 7'b1111111, "zero_s1");
    pin(4'b1011, 7'b1000000, "zero_s2");
    pin(4'b0111, 7'b1111111, "zero_s3");

    pulse(4'd15, 4'd10, 1'b0);
    cyc(17);
    pin(4'b1110, 7'b1000000, "max_s0");
    pin(4'b1101, 7'b1111001, "max_s1");
    pin(4'b1011, 7'b0010010, "max_s2");
    pin(4'b0111, 7'b1111001, "max_s3");

    // Reset coinciding with a done rising edge.
    rst = 1'b1;
    bus.quotient = 4'd5; bus.done = 1'b1;
    cyc(1);
    chk("rstd_an", 32'(an), 32'(4'b1111));
    chk("rstd_seg", 32'(seg), 32'(BLANK));
    chk("rstd_valid", 32'(result_valid), 32'd0);
    rst = 1'b0; bus.done = 1'b0;
    cyc(1);
    chk("rstd_rel_seg", 32'(seg), 32'(DASH));
    chk("rstd_rel_valid", 32'(result_valid), 32'd0);
    cyc(10);

    // Mid-scan reset after a capture.
    pulse(4'd3, 4'd2, 1'b0);
    cyc(6);
    rst = 1'b1;
    cyc(1);
    chk("mid_an", 32'(an), 32'(4'b1111));
    chk("mid_valid", 32'(result_valid), 32'd0);
    rst = 1'b0;
    cyc(1);
    chk("mid_rel_an", 32'(an), 32'(4'b1110));
    chk("mid_rel_seg", 32'(seg), 32'(DASH));
    cyc(8);

    // done held high through reset release counts as a rising edge.
    bus.quotient = 4'd4; bus.remainder = 4'd6; bus.done = 1'b1;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    chk("thru_valid", 32'(result_valid), 32'd1);
    bus.done = 1'b0;
    cyc(17);
    pin(4'b1110, 7'b0000010, "thru_s0");
    cyc(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
